// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_arbiter
// Description : Round-robin arbiter sharing one APB master port among NB_REQ
//               req/gnt/rvalid requesters, with an ACCESS-phase watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_arbiter #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned NB_REQ         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  // requester side
  input  logic [NB_REQ-1:0]                         req_i,
  input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]     addr_i,
  input  logic [NB_REQ-1:0]                         we_i,
  input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]     wdata_i,
  output logic [NB_REQ-1:0]                         gnt_o,
  output logic [NB_REQ-1:0]                         rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]                 rdata_o,
  output logic                                      err_o,
  // APB master side
  output logic [APB_ADDR_WIDTH-1:0]                 paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                 pwdata_o,
  output logic                                      pwrite_o,
  output logic                                      psel_o,
  output logic                                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0]                 prdata_i,
  input  logic                                      pready_i,
  input  logic                                      pslverr_i
);

  localparam int unsigned IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  // Wide enough to hold TIMEOUT_CYCLES itself, so the limit compare never wraps.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0]  PTR_RESET  = IDX_W'(NB_REQ - 1);
  localparam logic [NB_REQ-1:0] ONE_HOT0   = NB_REQ'(1);
  localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                    state_q;
  logic [IDX_W-1:0]          ptr_q;
  logic [IDX_W-1:0]          idx_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic                      pwrite_q;
  logic                      psel_q;
  logic                      penable_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [NB_REQ-1:0]         rvalid_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      err_q;

  logic                      win_valid;
  logic [IDX_W-1:0]          win_idx;
  logic [IDX_W-1:0]          cand;
  logic [NB_REQ-1:0]         gnt;
  logic [CNT_W-1:0]          cnt_d;
  logic                      timeout_hit;

  // Round-robin search: first set request strictly after the last winner.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      cand = IDX_W'((32'(ptr_q) + 32'd1 + i) % NB_REQ);
      if (!win_valid && req_i[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Grant is combinational so the request is captured in the cycle it is seen.
  always_comb begin
    gnt = '0;
    if ((state_q == S_IDLE) && win_valid) begin
      gnt[win_idx] = 1'b1;
    end
  end

  // Watchdog fires on the ACCESS cycle that would make the count reach the limit.
  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    timeout_hit = TIMEOUT_EN && !pready_i && (cnt_d == CNT_LIMIT);
  end

  // Transfer sequencer: IDLE -> SETUP -> ACCESS, with registered APB and response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= PTR_RESET;
      idx_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      cnt_q     <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      // Response outputs are single-cycle pulses unless a transfer ends below.
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            ptr_q    <= win_idx;
            idx_q    <= win_idx;
            paddr_q  <= addr_i[win_idx];
            pwrite_q <= we_i[win_idx];
            pwdata_q <= wdata_i[win_idx];
            psel_q   <= 1'b1;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready_i) begin
            // A slave response in the timeout cycle still counts as a normal completion.
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= ONE_HOT0 << idx_q;
            rdata_q   <= pwrite_q ? '0 : prdata_i;
            err_q     <= pslverr_i;
            state_q   <= S_IDLE;
          end else if (timeout_hit) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= ONE_HOT0 << idx_q;
            err_q     <= 1'b1;
            state_q   <= S_IDLE;
          end else if (TIMEOUT_EN) begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_o     = gnt;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pwrite_o  = pwrite_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_arbiter
// Description : Directed self-checking bench for apb_master_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_arbiter;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [1:0]       req_i = '0;
  logic [1:0][31:0] addr_i = '0;
  logic [1:0]       we_i = '0;
  logic [1:0][31:0] wdata_i = '0;
  logic [1:0]       gnt_o;
  logic [1:0]       rvalid_o;
  logic [31:0]      rdata_o;
  logic             err_o;
  logic [31:0]      paddr_o;
  logic [31:0]      pwdata_o;
  logic             pwrite_o;
  logic             psel_o;
  logic             penable_o;
  logic [31:0]      prdata_i = '0;
  logic             pready_i = 1'b0;
  logic             pslverr_i = 1'b0;

  int total = 0;
  int bad   = 0;

  apb_master_arbiter #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .NB_REQ        (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .paddr_o  (paddr_o),
    .pwdata_o (pwdata_o),
    .pwrite_o (pwrite_o),
    .psel_o   (psel_o),
    .penable_o(penable_o),
    .prdata_i (prdata_i),
    .pready_i (pready_i),
    .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = '0;
    pready_i = 1'b0;
    pslverr_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({gnt_o, rvalid_o, err_o, psel_o, penable_o, pwrite_o} !== 9'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {gnt_o, rvalid_o, err_o, psel_o, penable_o, pwrite_o});
    end
    total++;
    if ({paddr_o, pwdata_o, rdata_o} !== 96'b0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {paddr_o, pwdata_o, rdata_o});
    end
  endtask

  task automatic test_single_read();
    req_i = 2'b01; addr_i[0] = 32'h1A10_0000; we_i = 2'b00;
    #1;
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL read_gnt: got %b want 01", gnt_o); end
    step();
    req_i = 2'b00;
    pready_i = 1'b1; prdata_i = 32'hCAFE_0001;
    total++;
    if ({psel_o, penable_o, pwrite_o} !== 3'b100) begin
      bad++; $display("FAIL read_setup: got %b want 100", {psel_o, penable_o, pwrite_o});
    end
    total++;
    if (paddr_o !== 32'h1A10_0000) begin bad++; $display("FAIL read_paddr: got %h want 1a100000", paddr_o); end
    step();
    total++;
    if ({psel_o, penable_o, rvalid_o} !== 4'b1100) begin
      bad++; $display("FAIL read_access: got %b want 1100", {psel_o, penable_o, rvalid_o});
    end
    step();
    pready_i = 1'b0; prdata_i = '0;
    total++;
    if ({rvalid_o, err_o, psel_o, penable_o} !== 5'b01000) begin
      bad++; $display("FAIL read_rvalid: got %b want 01000", {rvalid_o, err_o, psel_o, penable_o});
    end
    total++;
    if (rdata_o !== 32'hCAFE_0001) begin bad++; $display("FAIL read_rdata: got %h want cafe0001", rdata_o); end
    step();
    total++;
    if (rvalid_o !== 2'b00) begin bad++; $display("FAIL read_pulse: got %b want 00", rvalid_o); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_gnt;
    logic [1:0] prev_gnt;
    do_reset();
    addr_i[0] = 32'h0000_0100; addr_i[1] = 32'h0000_0200; we_i = 2'b00;
    req_i = 2'b11; pready_i = 1'b1;
    prev_gnt = 2'b00;
    for (int k = 0; k < 4; k++) begin
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      prdata_i = 32'h1000_0000 + k;
      #1;
      total++;
      if (gnt_o !== exp_gnt) begin bad++; $display("FAIL b2b_gnt%0d: got %b want %b", k, gnt_o, exp_gnt); end
      if (k > 0) begin
        total++;
        if (rvalid_o !== prev_gnt || rdata_o !== 32'h1000_0000 + k - 1) begin
          bad++; $display("FAIL b2b_rvalid%0d: got %b/%h want %b/%h", k, rvalid_o, rdata_o, prev_gnt, 32'h1000_0000 + k - 1);
        end
      end
      step();
      total++;
      if (gnt_o !== 2'b00 || paddr_o !== ((k % 2 == 0) ? 32'h100 : 32'h200)) begin
        bad++; $display("FAIL b2b_setup%0d: got %b/%h want 00/%h", k, gnt_o, paddr_o, (k % 2 == 0) ? 32'h100 : 32'h200);
      end
      step();
      total++;
      if (gnt_o !== 2'b00 || penable_o !== 1'b1) begin
        bad++; $display("FAIL b2b_access%0d: got %b/%b want 00/1", k, gnt_o, penable_o);
      end
      step();
      prev_gnt = exp_gnt;
    end
    req_i = 2'b00;
    #1;
    total++;
    if (rvalid_o !== 2'b10 || rdata_o !== 32'h1000_0003 || gnt_o !== 2'b00) begin
      bad++; $display("FAIL b2b_last: got %b/%h/%b want 10/10000003/00", rvalid_o, rdata_o, gnt_o);
    end
    pready_i = 1'b0;
    step();
  endtask

  task automatic test_write_wait_err();
    req_i = 2'b01; we_i = 2'b01; addr_i[0] = 32'h1A10_2000; wdata_i[0] = 32'hDEAD_BEEF;
    #1;
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL wr_gnt: got %b want 01", gnt_o); end
    step();
    req_i = 2'b00;
    total++;
    if ({psel_o, penable_o, pwrite_o} !== 3'b101) begin
      bad++; $display("FAIL wr_setup: got %b want 101", {psel_o, penable_o, pwrite_o});
    end
    step();
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({psel_o, penable_o} !== 2'b11 || paddr_o !== 32'h1A10_2000 || pwdata_o !== 32'hDEAD_BEEF) begin
        bad++; $display("FAIL wr_wait%0d: got %b/%h/%h want 11/1a102000/deadbeef", i, {psel_o, penable_o}, paddr_o, pwdata_o);
      end
      if (i == 5) begin
        pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'h5555_5555;
      end
      step();
    end
    pready_i = 1'b0; pslverr_i = 1'b0; we_i = 2'b00;
    total++;
    if ({rvalid_o, err_o, penable_o, psel_o} !== 5'b01100 || rdata_o !== 32'h0) begin
      bad++; $display("FAIL wr_resp: got %b/%h want 01100/0", {rvalid_o, err_o, penable_o, psel_o}, rdata_o);
    end
    step();
  endtask

  task automatic test_timeout();
    req_i = 2'b10; we_i = 2'b00; addr_i[1] = 32'h1A10_3000;
    #1;
    total++;
    if (gnt_o !== 2'b10) begin bad++; $display("FAIL to_gnt: got %b want 10", gnt_o); end
    step();
    req_i = 2'b00;
    step();
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({psel_o, penable_o, rvalid_o} !== 4'b1100) begin
        bad++; $display("FAIL to_access%0d: got %b want 1100", i, {psel_o, penable_o, rvalid_o});
      end
      step();
    end
    total++;
    if ({psel_o, penable_o, rvalid_o, err_o} !== 5'b00101 || rdata_o !== 32'h0) begin
      bad++; $display("FAIL to_resp: got %b/%h want 00101/0", {psel_o, penable_o, rvalid_o, err_o}, rdata_o);
    end
    req_i = 2'b01; addr_i[0] = 32'h1A10_4000;
    #1;
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL to_regrant: got %b want 01", gnt_o); end
    step();
    req_i = 2'b00; pready_i = 1'b1; prdata_i = 32'h0BAD_F00D;
    step();
    step();
    pready_i = 1'b0;
    total++;
    if ({rvalid_o, err_o} !== 3'b010 || rdata_o !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL to_after: got %b/%h want 010/0badf00d", {rvalid_o, err_o}, rdata_o);
    end
    step();
  endtask

  task automatic test_timeout_boundary();
    req_i = 2'b10; we_i = 2'b00; addr_i[1] = 32'h1A10_5000;
    #1;
    total++;
    if (gnt_o !== 2'b10) begin bad++; $display("FAIL tb_gnt: got %b want 10", gnt_o); end
    step();
    req_i = 2'b00;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        pready_i = 1'b1; prdata_i = 32'hA5A5_0008; pslverr_i = 1'b0;
      end
      step();
    end
    pready_i = 1'b0;
    total++;
    if ({rvalid_o, err_o} !== 3'b100 || rdata_o !== 32'hA5A5_0008) begin
      bad++; $display("FAIL tb_resp: got %b/%h want 100/a5a50008", {rvalid_o, err_o}, rdata_o);
    end
    step();
  endtask

  task automatic test_reset_mid();
    req_i = 2'b01; addr_i[0] = 32'h1A10_6000;
    #1;
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL rm_gnt: got %b want 01", gnt_o); end
    step();
    req_i = 2'b00;
    step();
    total++;
    if ({psel_o, penable_o} !== 2'b11) begin bad++; $display("FAIL rm_access: got %b want 11", {psel_o, penable_o}); end
    rst_i = 1'b1; pready_i = 1'b1; prdata_i = 32'h7777_7777;
    step();
    total++;
    if ({psel_o, penable_o, rvalid_o, gnt_o} !== 6'b0) begin
      bad++; $display("FAIL rm_abort: got %b want 000000", {psel_o, penable_o, rvalid_o, gnt_o});
    end
    rst_i = 1'b0; pready_i = 1'b0;
    step();
    total++;
    if ({psel_o, rvalid_o} !== 3'b0) begin bad++; $display("FAIL rm_norvalid: got %b want 000", {psel_o, rvalid_o}); end
    req_i = 2'b11;
    #1;
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL rm_prio: got %b want 01", gnt_o); end
    step();
    req_i = 2'b00; pready_i = 1'b1; prdata_i = 32'h0000_00AA;
    step();
    step();
    pready_i = 1'b0;
    total++;
    if (rvalid_o !== 2'b01 || rdata_o !== 32'h0000_00AA) begin
      bad++; $display("FAIL rm_done: got %b/%h want 01/000000aa", rvalid_o, rdata_o);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_wait_err();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares the single APB slave port of the peripheral bus wrapper (UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC control, debug) among NB_REQ requesters, e.g. the core data bridge and the debug/DMA bridge.
- Performs round-robin arbitration over a req/gnt/rvalid interface and sequences the APB SETUP/ACCESS phases.
- Terminates hung transfers with a watchdog timeout that returns an error.

Parameters:
- APB_ADDR_WIDTH, 32, address width of requesters and APB.
- APB_DATA_WIDTH, 32, data width of requesters and APB.
- NB_REQ, 2, number of requesters (≥2).
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before forced error; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  NB_REQ  per-requester transfer request, held until gnt.
- addr_i  in  NB_REQ x APB_ADDR_WIDTH  per-requester address.
- we_i  in  NB_REQ  per-requester write enable (1 = write).
- wdata_i  in  NB_REQ x APB_DATA_WIDTH  per-requester write data.
- gnt_o  out  NB_REQ  one-hot grant; request captured in that cycle.
- rvalid_o  out  NB_REQ  one-hot single-cycle completion pulse.
- rdata_o  out  APB_DATA_WIDTH  read data, valid with rvalid_o (shared by all requesters).
- err_o  out  1  error flag, valid with rvalid_o (PSLVERR or timeout).
- paddr_o  out  APB_ADDR_WIDTH  APB PADDR.
- pwdata_o  out  APB_DATA_WIDTH  APB PWDATA.
- pwrite_o  out  1  APB PWRITE.
- psel_o  out  1  APB PSEL.
- penable_o  out  1  APB PENABLE.
- prdata_i  in  APB_DATA_WIDTH  APB PRDATA.
- pready_i  in  1  APB PREADY.
- pslverr_i  in  1  APB PSLVERR.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS.
  - Reset → IDLE.
  - Every output resets to 0.
  - Round-robin pointer resets to NB_REQ-1, so requester 0 has first priority.
- IDLE:
  - If any req_i is set, the winner is the first set bit searching upward from pointer+1 (mod NB_REQ).
  - gnt_o[winner] is asserted combinationally in the same cycle.
  - addr/we/wdata and the winner index are registered; pointer updates to the winner.
  - Next state is SETUP. With no request, stay in IDLE with gnt_o = 0.
- SETUP:
  - psel_o=1, penable_o=0; paddr/pwrite/pwdata driven from the registered copy.
  - Next state is ACCESS unconditionally.
- ACCESS:
  - psel_o=1, penable_o=1; address and control held stable.
  - On pready_i=1: transfer completes and the state returns to IDLE.
  - On the next cycle, rvalid_o[winner]=1 for exactly one cycle, with:
    - rdata_o = captured prdata_i for reads; 0 for writes;
    - err_o = captured pslverr_i.
- Timeout:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i=0.
  - When it reaches TIMEOUT_CYCLES, psel/penable drop and the state returns to IDLE.
  - rvalid_o[winner] then pulses next cycle with err_o=1 and rdata_o=0.
  - pready_i arriving in the same cycle as the timeout wins: normal completion.
  - The counter width must hold TIMEOUT_CYCLES without wrap.
- Throughput:
  - The IDLE cycle that carries rvalid_o may also issue a new grant.
  - Back-to-back zero-wait transfers therefore complete every 3 cycles: gnt, SETUP, ACCESS.
- gnt_o is never asserted outside IDLE. Only one transfer is outstanding at a time.
- Requests dropped before gnt are ignored; no grant is issued to a deasserted req.
- Reset mid-transfer:
  - Returns to IDLE immediately and deasserts psel/penable the next cycle.
  - No rvalid_o is issued for the aborted transfer.
- psel_o/penable_o/paddr_o/pwrite_o/pwdata_o are registered. paddr_o holds its last value in IDLE.

Test Plan:
- Single read, req_i=01, addr 0x1A10_0000, pready_i high on the first ACCESS cycle, prdata_i=0xCAFE_0001:
  - gnt_o=01 in cycle 0; SETUP in cycle 1; ACCESS in cycle 2;
  - rvalid_o=01 in cycle 3 with rdata_o=0xCAFE_0001, err_o=0.
- Both requesters held continuously for 4 transfers:
  - grants alternate 01,10,01,10;
  - each grant is 3 cycles apart with zero-wait slaves.
- Write with 5 wait states, then pslverr_i=1 with pready_i:
  - penable_o high for 6 cycles with paddr/pwdata stable;
  - rvalid_o pulses with err_o=1, rdata_o=0.
- TIMEOUT_CYCLES=8, pready_i held 0:
  - ACCESS lasts 8 cycles; psel_o drops; rvalid_o pulses with err_o=1.
  - A subsequent request is granted normally.
- rst_i asserted during ACCESS:
  - the next cycle shows psel_o=penable_o=0, state IDLE, no rvalid_o;
  - after release, requester 0 wins a simultaneous 11 request.
- TIMEOUT_CYCLES=8, pready_i asserted exactly on the 8th ACCESS cycle:
  - normal completion with captured prdata_i and err_o=pslverr_i.
